// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg
//   Shared definitions for the UART receiver: FSM state codes (3-bit code
//   space shared with the transmitter side, S_DATA added at the end) and the
//   data-length encoding helper.
//   No ports; import with "import uart_rx_pkg::*;".
package uart_rx_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_PARITY = 3'd2,
        S_STOP_2 = 3'd3,
        S_STOP   = 3'd4,
        S_DATA   = 3'd5
    } state_t;

    // Length field encodes the number of data bits minus six.
    localparam logic [3:0] LEN_BASE = 4'd6;

    function automatic logic [3:0] data_bits(input logic [1:0] len);
        return {2'b00, len} + LEN_BASE;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// uart_sync
//   Two-flop synchronizer for an asynchronous input line. Both stages reset to
//   RESET_VAL so an idle-high line reads as idle straight out of reset.
//   Ports:
//     i_clk  clock
//     i_rst  synchronous active-high reset
//     i_d    asynchronous input
//     o_q    synchronized output (two i_clk cycles of latency)
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = i_d;
        sync_d = meta_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx
//   UART receiver. Oversamples the synchronized RX line on i_ce ticks, deframes
//   start / 6-9 data bits (LSB first) / optional parity / 1 or 2 stop bits and
//   holds one word until i_read.
//   Ports:
//     i_clk, i_rst           clock, synchronous active-high reset
//     i_ce                   oversample tick (OVERSAMPLE x baud)
//     i_rx                   asynchronous RX line, idle high
//     i_length               data bits = i_length + 6
//     i_stop2, i_parity      two stop bits / parity present
//     i_odd                  odd parity (0 = even)
//     i_read                 consume the held word, clears valid and flags
//     o_data                 held word, right-justified
//     o_valid                word held
//     o_parity_err           parity mismatch of held word
//     o_frame_err            a stop bit of the held word sampled low
//     o_overrun              a word was dropped while o_valid was set
//     o_busy                 frame in progress
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ce,
    input  logic       i_rx,
    input  logic [1:0] i_length,
    input  logic       i_stop2,
    input  logic       i_parity,
    input  logic       i_odd,
    input  logic       i_read,
    output logic [8:0] o_data,
    output logic       o_valid,
    output logic       o_parity_err,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_busy
);

    localparam logic [3:0] CNT_LAST  = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] CNT_EARLY = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] CNT_MID   = 4'(OVERSAMPLE / 2);
    localparam logic [3:0] CNT_LATE  = 4'(OVERSAMPLE / 2 + 1);

    logic   rx_s;
    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] bit_q, bit_d;
    logic [8:0] shreg_q, shreg_d;
    logic [1:0] maj_q, maj_d;
    logic       mid_q, mid_d;
    logic       prev_q, prev_d;
    logic       armed_q, armed_d;
    logic [1:0] warm_q, warm_d;
    logic [1:0] len_q, len_d;
    logic       stop2_q, stop2_d, par_q, par_d, odd_q, odd_d;
    logic       fr_perr_q, fr_perr_d, fr_ferr_q, fr_ferr_d;
    logic [8:0] data_q, data_d;
    logic       valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;
    logic       sample_bit, bit_tick, done;

    uart_sync #(.RESET_VAL(1'b1)) u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_rx),
        .o_q   (rx_s)
    );

    // Majority of the two stored samples and the live one at the decision tick.
    assign sample_bit = (maj_q[0] & maj_q[1]) | (maj_q[0] & rx_s) | (maj_q[1] & rx_s);

    // The decision tick only counts once the mid sample of the current bit has
    // been taken; this masks the counter passing CNT_LATE right after the
    // realignment at start confirmation.
    assign bit_tick = i_ce && (cnt_q == CNT_LATE) && mid_q;

    // The synchronizer output reflects the real line only after warm_q fills.
    // Start detection is armed once the line has genuinely been seen high, so
    // a line held low from reset cannot fake a falling edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        maj_d     = maj_q;
        mid_d     = mid_q;
        prev_d    = prev_q;
        len_d     = len_q;
        stop2_d   = stop2_q;
        par_d     = par_q;
        odd_d     = odd_q;
        fr_perr_d = fr_perr_q;
        fr_ferr_d = fr_ferr_q;
        done      = 1'b0;
        warm_d    = {warm_q[0], 1'b1};
        armed_d   = armed_q | (warm_q[1] & rx_s);

        if (i_ce) begin
            prev_d = rx_s;
            cnt_d  = (cnt_q == CNT_LAST) ? 4'd0 : cnt_q + 4'd1;
            if (cnt_q == CNT_EARLY) maj_d[0] = rx_s;
            if (cnt_q == CNT_MID) begin
                maj_d[1] = rx_s;
                mid_d    = 1'b1;
            end
            if (bit_tick) mid_d = 1'b0;

            unique case (state_q)
                S_IDLE: begin
                    if (armed_q && prev_q && !rx_s) begin
                        state_d = S_START;
                        cnt_d   = 4'd0;
                    end
                end
                S_START: begin
                    if (cnt_q == CNT_EARLY) begin
                        if (rx_s) begin
                            state_d = S_IDLE;
                        end else begin
                            // Realign so the start centre sits at CNT_MID-1;
                            // every later bit centre then lands on CNT_MID.
                            state_d   = S_DATA;
                            cnt_d     = CNT_LATE;
                            mid_d     = 1'b0;
                            bit_d     = 4'd0;
                            shreg_d   = 9'd0;
                            fr_perr_d = 1'b0;
                            fr_ferr_d = 1'b0;
                            len_d     = i_length;
                            stop2_d   = i_stop2;
                            par_d     = i_parity;
                            odd_d     = i_odd;
                        end
                    end
                end
                S_DATA: begin
                    if (bit_tick) begin
                        shreg_d = {sample_bit, shreg_q[8:1]};
                        bit_d   = bit_q + 4'd1;
                        if (bit_q == data_bits(len_q) - 4'd1)
                            state_d = par_q ? S_PARITY : (stop2_q ? S_STOP_2 : S_STOP);
                    end
                end
                S_PARITY: begin
                    if (bit_tick) begin
                        fr_perr_d = sample_bit ^ (^shreg_q) ^ odd_q;
                        state_d   = stop2_q ? S_STOP_2 : S_STOP;
                    end
                end
                S_STOP_2: begin
                    if (bit_tick) begin
                        if (!sample_bit) fr_ferr_d = 1'b1;
                        state_d = S_STOP;
                    end
                end
                S_STOP: begin
                    if (bit_tick) begin
                        done    = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Holding register: i_read clears it; a completing frame loads it when
    // empty or when being read in the same cycle, otherwise flags an overrun.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;
        if (i_read) begin
            valid_d = 1'b0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
            ovr_d   = 1'b0;
        end
        if (done) begin
            if (!valid_q || i_read) begin
                data_d  = shreg_q >> (2'd3 - len_q);
                valid_d = 1'b1;
                perr_d  = fr_perr_q;
                ferr_d  = fr_ferr_q | ~sample_bit;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            bit_q     <= 4'd0;
            shreg_q   <= 9'd0;
            maj_q     <= 2'b11;
            mid_q     <= 1'b0;
            prev_q    <= 1'b1;
            armed_q   <= 1'b0;
            warm_q    <= 2'b00;
            len_q     <= 2'd0;
            stop2_q   <= 1'b0;
            par_q     <= 1'b0;
            odd_q     <= 1'b0;
            fr_perr_q <= 1'b0;
            fr_ferr_q <= 1'b0;
            data_q    <= 9'd0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            maj_q     <= maj_d;
            mid_q     <= mid_d;
            prev_q    <= prev_d;
            armed_q   <= armed_d;
            warm_q    <= warm_d;
            len_q     <= len_d;
            stop2_q   <= stop2_d;
            par_q     <= par_d;
            odd_q     <= odd_d;
            fr_perr_q <= fr_perr_d;
            fr_ferr_q <= fr_ferr_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign o_data       = data_q;
    assign o_valid      = valid_q;
    assign o_parity_err = perr_q;
    assign o_frame_err  = ferr_q;
    assign o_overrun    = ovr_q;
    assign o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx
//   Self-checking bench for uart_rx: a table of directed frames, a set of
//   hand-written corner sequences and randomized frames checked against a
//   frame-level reference model of the receiver's holding register.
module tb_uart_rx;

    localparam int OS = 16;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_ce = 1'b0;
    logic       i_rx = 1'b1;
    logic [1:0] i_length = 2'd2;
    logic       i_stop2 = 1'b0;
    logic       i_parity = 1'b0;
    logic       i_odd = 1'b0;
    logic       i_read = 1'b0;
    logic [8:0] o_data;
    logic       o_valid, o_parity_err, o_frame_err, o_overrun, o_busy;

    int tests = 0;
    int failed = 0;
    logic busySeen;

    uart_rx #(.OVERSAMPLE(OS)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_ce         (i_ce),
        .i_rx         (i_rx),
        .i_length     (i_length),
        .i_stop2      (i_stop2),
        .i_parity     (i_parity),
        .i_odd        (i_odd),
        .i_read       (i_read),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .o_parity_err (o_parity_err),
        .o_frame_err  (o_frame_err),
        .o_overrun    (o_overrun),
        .o_busy       (o_busy)
    );

    // Clock, and an oversample tick on every second rising edge.
    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) i_ce = ~i_ce;

    typedef struct {
        logic [1:0] len;
        logic       stop2, par, odd;
        logic [8:0] data;
        logic       flipPar, stopLow, readAfter;
        logic [8:0] expData;
        logic       expPerr, expFerr, expOvr;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input logic [8:0] actual, input logic [8:0] expected);
        tests++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic waitTicks(input int n);
        repeat (n) begin
            @(posedge i_clk);
            while (!i_ce) @(posedge i_clk);
        end
        #1;
    endtask

    task automatic sendBit(input logic b);
        i_rx = b;
        waitTicks(OS);
    endtask

    task automatic pulseReset();
        @(negedge i_clk) i_rst = 1'b1;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    task automatic readWord();
        @(negedge i_clk) i_read = 1'b1;
        @(negedge i_clk) i_read = 1'b0;
    endtask

    // Drives one complete frame; the config inputs are scrambled once the
    // start bit is over to show the receiver uses the latched config.
    task automatic applyStimulus(input logic [1:0] len, input logic st2, input logic par,
                                 input logic odd, input logic [8:0] data,
                                 input logic flip, input logic stopLow);
        int bits;
        logic pbit;
        bits = int'(len) + 6;
        i_length = len;
        i_stop2  = st2;
        i_parity = par;
        i_odd    = odd;
        sendBit(1'b0);
        busySeen = o_busy;
        i_length = 2'($urandom);
        i_stop2  = 1'($urandom);
        i_parity = 1'($urandom);
        i_odd    = 1'($urandom);
        for (int i = 0; i < bits; i++) sendBit(data[i]);
        if (par) begin
            pbit = (^data) ^ odd ^ flip;
            sendBit(pbit);
        end
        if (st2) begin
            sendBit(~stopLow);
            sendBit(1'b1);
        end else begin
            sendBit(~stopLow);
        end
        i_rx = 1'b1;
        waitTicks(3);
    endtask

    initial begin
        logic [8:0] mData;
        logic mValid, mPerr, mFerr, mOvr;
        logic sawBusy;

        // 8N1 A5, 6E2 2B, 6E2 2B bad parity, 9O1 1FF, 9O1 stop low,
        // overrun pair 11/22, 7O2 3C with first stop low.
        vecs[0] = '{2'd2, 1'b0, 1'b0, 1'b0, 9'h0A5, 1'b0, 1'b0, 1'b1, 9'h0A5, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{2'd0, 1'b1, 1'b1, 1'b0, 9'h02B, 1'b0, 1'b0, 1'b1, 9'h02B, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{2'd0, 1'b1, 1'b1, 1'b0, 9'h02B, 1'b1, 1'b0, 1'b1, 9'h02B, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{2'd3, 1'b0, 1'b1, 1'b1, 9'h1FF, 1'b0, 1'b0, 1'b1, 9'h1FF, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{2'd3, 1'b0, 1'b1, 1'b1, 9'h1FF, 1'b0, 1'b1, 1'b1, 9'h1FF, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{2'd2, 1'b0, 1'b0, 1'b0, 9'h011, 1'b0, 1'b0, 1'b0, 9'h011, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{2'd2, 1'b0, 1'b0, 1'b0, 9'h022, 1'b0, 1'b0, 1'b1, 9'h011, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{2'd1, 1'b1, 1'b1, 1'b1, 9'h03C, 1'b0, 1'b1, 1'b1, 9'h03C, 1'b0, 1'b1, 1'b0};

        repeat (3) @(negedge i_clk);
        checkOutput("reset_valid", 9'(o_valid), 9'd0);
        checkOutput("reset_busy", 9'(o_busy), 9'd0);
        i_rst = 1'b0;
        @(negedge i_clk);
        checkOutput("reset_data", o_data, 9'd0);
        checkOutput("reset_flags", {6'd0, o_parity_err, o_frame_err, o_overrun}, 9'd0);
        waitTicks(4);

        // Directed frame table.
        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v].len, vecs[v].stop2, vecs[v].par, vecs[v].odd,
                          vecs[v].data, vecs[v].flipPar, vecs[v].stopLow);
            @(negedge i_clk);
            checkOutput($sformatf("vec%0d_busy", v), 9'(busySeen), 9'd1);
            checkOutput($sformatf("vec%0d_valid", v), 9'(o_valid), 9'd1);
            checkOutput($sformatf("vec%0d_data", v), o_data, vecs[v].expData);
            checkOutput($sformatf("vec%0d_perr", v), 9'(o_parity_err), 9'(vecs[v].expPerr));
            checkOutput($sformatf("vec%0d_ferr", v), 9'(o_frame_err), 9'(vecs[v].expFerr));
            checkOutput($sformatf("vec%0d_ovr", v), 9'(o_overrun), 9'(vecs[v].expOvr));
            if (vecs[v].readAfter) begin
                readWord();
                checkOutput($sformatf("vec%0d_read_valid", v), 9'(o_valid), 9'd0);
                checkOutput($sformatf("vec%0d_read_flags", v),
                            {6'd0, o_parity_err, o_frame_err, o_overrun}, 9'd0);
            end
        end

        // Glitch shorter than half a bit.
        i_rx = 1'b0;
        waitTicks(4);
        checkOutput("glitch_detected", 9'(o_busy), 9'd1);
        i_rx = 1'b1;
        waitTicks(OS / 2);
        checkOutput("glitch_busy", 9'(o_busy), 9'd0);
        checkOutput("glitch_valid", 9'(o_valid), 9'd0);

        // Reset in the middle of data bit 3, with a word already held.
        applyStimulus(2'd2, 1'b0, 1'b0, 1'b0, 9'h077, 1'b0, 1'b0);
        sendBit(1'b0);
        for (int i = 0; i < 3; i++) sendBit(1'b1);
        i_rx = 1'b1;
        waitTicks(OS / 2);
        pulseReset();
        @(negedge i_clk);
        checkOutput("midreset_busy", 9'(o_busy), 9'd0);
        checkOutput("midreset_valid", 9'(o_valid), 9'd0);
        checkOutput("midreset_data", o_data, 9'd0);
        waitTicks(4);
        applyStimulus(2'd2, 1'b0, 1'b0, 1'b0, 9'h05A, 1'b0, 1'b0);
        @(negedge i_clk);
        checkOutput("after_reset_valid", 9'(o_valid), 9'd1);
        checkOutput("after_reset_data", o_data, 9'h05A);
        checkOutput("after_reset_flags", {6'd0, o_parity_err, o_frame_err, o_overrun}, 9'd0);
        readWord();

        // Line held low through reset must not start a frame.
        i_rx = 1'b0;
        pulseReset();
        sawBusy = 1'b0;
        for (int i = 0; i < 40; i++) begin
            waitTicks(1);
            if (o_busy) sawBusy = 1'b1;
        end
        checkOutput("lowreset_busy", 9'(sawBusy), 9'd0);
        checkOutput("lowreset_valid", 9'(o_valid), 9'd0);
        i_rx = 1'b1;
        waitTicks(4);
        applyStimulus(2'd2, 1'b0, 1'b0, 1'b0, 9'h033, 1'b0, 1'b0);
        @(negedge i_clk);
        checkOutput("lowreset_frame_data", o_data, 9'h033);
        readWord();

        // Break: line low for a whole 8N1 frame and beyond.
        i_length = 2'd2;
        i_stop2  = 1'b0;
        i_parity = 1'b0;
        i_rx     = 1'b0;
        waitTicks(10 * OS);
        @(negedge i_clk);
        checkOutput("break_valid", 9'(o_valid), 9'd1);
        checkOutput("break_data", o_data, 9'd0);
        checkOutput("break_ferr", 9'(o_frame_err), 9'd1);
        sawBusy = 1'b0;
        for (int i = 0; i < 40; i++) begin
            waitTicks(1);
            if (o_busy) sawBusy = 1'b1;
        end
        checkOutput("break_no_restart", 9'(sawBusy), 9'd0);
        i_rx = 1'b1;
        waitTicks(4);
        readWord();
        checkOutput("break_read_valid", 9'(o_valid), 9'd0);

        // Randomized frames against the frame-level reference model.
        mData = 9'd0; mValid = 1'b0; mPerr = 1'b0; mFerr = 1'b0; mOvr = 1'b0;
        for (int n = 0; n < 40; n++) begin
            logic [1:0] len;
            logic st2, par, odd, flip, stopLow, doRead, pbit, perr;
            logic [8:0] data;
            int bits;
            len     = 2'($urandom);
            st2     = 1'($urandom);
            par     = 1'($urandom);
            odd     = 1'($urandom);
            flip    = ($urandom_range(3) == 0);
            stopLow = ($urandom_range(4) == 0);
            doRead  = ($urandom_range(3) != 0);
            bits    = int'(len) + 6;
            data    = 9'($urandom) & 9'((1 << bits) - 1);
            applyStimulus(len, st2, par, odd, data, flip, stopLow);
            pbit = (^data) ^ odd ^ flip;
            perr = par && ((($countones(data) + int'(pbit)) % 2) != int'(odd));
            if (!mValid) begin
                mData = data; mValid = 1'b1; mPerr = perr; mFerr = stopLow;
            end else begin
                mOvr = 1'b1;
            end
            @(negedge i_clk);
            checkOutput($sformatf("rnd%0d_valid", n), 9'(o_valid), 9'(mValid));
            checkOutput($sformatf("rnd%0d_data", n), o_data, mData);
            checkOutput($sformatf("rnd%0d_perr", n), 9'(o_parity_err), 9'(mPerr));
            checkOutput($sformatf("rnd%0d_ferr", n), 9'(o_frame_err), 9'(mFerr));
            checkOutput($sformatf("rnd%0d_ovr", n), 9'(o_overrun), 9'(mOvr));
            if (doRead) begin
                readWord();
                mValid = 1'b0; mPerr = 1'b0; mFerr = 1'b0; mOvr = 1'b0;
                checkOutput($sformatf("rnd%0d_read", n), 9'(o_valid), 9'd0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
